// File: rtl/floo_rd_offload_alu_pkg.sv
// Shared types for the offload reduction ALU: op encoding and legality check.
// The op encoding matches the reduction op field carried in the router header.
package floo_rd_offload_alu_pkg;

    localparam int unsigned RdOpWidth = 5;

    typedef enum logic [RdOpWidth-1:0] {
        RdAdd  = 5'd0,
        RdMinS = 5'd1,
        RdMaxS = 5'd2,
        RdMinU = 5'd3,
        RdMaxU = 5'd4,
        RdAnd  = 5'd5,
        RdOr   = 5'd6,
        RdXor  = 5'd7
    } rd_alu_op_e;

    function automatic logic rd_alu_op_legal(input rd_alu_op_e op);
        case (op)
            RdAdd, RdMinS, RdMaxS, RdMinU, RdMaxU, RdAnd, RdOr, RdXor: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/floo_rd_offload_alu_lane.sv
// One ElemWidth-wide lane of the reduction ALU, purely combinational.
// Unsupported ops pass operand a through and drop legal_o.
module floo_rd_offload_alu_lane
    import floo_rd_offload_alu_pkg::*;
#(
    parameter int unsigned ElemWidth = 32
) (
    input  rd_alu_op_e           op_i,
    input  logic [ElemWidth-1:0] a_i,
    input  logic [ElemWidth-1:0] b_i,
    output logic [ElemWidth-1:0] result_o,
    output logic                 legal_o
);

    logic lt_s;
    logic lt_u;

    assign lt_s = $signed(a_i) < $signed(b_i);
    assign lt_u = a_i < b_i;

    always_comb begin
        legal_o  = rd_alu_op_legal(op_i);
        result_o = a_i;
        case (op_i)
            RdAdd:   result_o = a_i + b_i;
            RdMinS:  result_o = lt_s ? a_i : b_i;
            RdMaxS:  result_o = lt_s ? b_i : a_i;
            RdMinU:  result_o = lt_u ? a_i : b_i;
            RdMaxU:  result_o = lt_u ? b_i : a_i;
            RdAnd:   result_o = a_i & b_i;
            RdOr:    result_o = a_i | b_i;
            RdXor:   result_o = a_i ^ b_i;
            default: result_o = a_i;
        endcase
    end

endmodule

// File: rtl/floo_rd_offload_alu.sv
// Responder for the router offload-reduction port: lane-wise integer SIMD ALU
// followed by an elastic, stallable pipeline of NumStages registers.
module floo_rd_offload_alu
    import floo_rd_offload_alu_pkg::*;
#(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned ElemWidth = 32,
    parameter int unsigned NumStages = 2,
    parameter type         op_t      = rd_alu_op_e
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  op_t                  offload_req_op_i,
    input  logic [DataWidth-1:0] offload_req_operand1_i,
    input  logic [DataWidth-1:0] offload_req_operand2_i,
    input  logic                 offload_req_valid_i,
    output logic                 offload_req_ready_o,
    output logic [DataWidth-1:0] offload_resp_result_o,
    output logic                 offload_resp_valid_o,
    input  logic                 offload_resp_ready_i,
    output logic                 illegal_op_o,
    output logic                 busy_o
);

    localparam int unsigned NumLanes  = DataWidth / ElemWidth;
    localparam int unsigned LastStage = NumStages - 1;

    if (DataWidth % ElemWidth != 0) begin : gen_width_check
        $error("DataWidth must be a multiple of ElemWidth");
    end
    if (NumStages < 1) begin : gen_stage_check
        $error("NumStages must be at least 1");
    end

    rd_alu_op_e                          req_op;
    logic [DataWidth-1:0]                req_result;
    logic [NumLanes-1:0]                 lane_legal;
    logic                                req_legal;

    logic [NumStages-1:0]                valid_q;
    logic [NumStages-1:0][DataWidth-1:0] data_q;
    logic [NumStages-1:0]                up_valid;
    logic [NumStages-1:0][DataWidth-1:0] up_data;
    logic [NumStages-1:0]                adv;
    logic                                illegal_q;

    assign req_op = rd_alu_op_e'(offload_req_op_i);

    for (genvar l = 0; l < NumLanes; l++) begin : gen_lane
        floo_rd_offload_alu_lane #(
            .ElemWidth(ElemWidth)
        ) u_lane (
            .op_i    (req_op),
            .a_i     (offload_req_operand1_i[l*ElemWidth +: ElemWidth]),
            .b_i     (offload_req_operand2_i[l*ElemWidth +: ElemWidth]),
            .result_o(req_result[l*ElemWidth +: ElemWidth]),
            .legal_o (lane_legal[l])
        );
    end

    assign req_legal = &lane_legal;

    // Closed form of the ready chain: a stage advances unless it and every stage
    // downstream of it are full while the output is stalled.
    function automatic logic [NumStages-1:0] stage_advance(input logic [NumStages-1:0] v,
                                                           input logic             out_ready);
        logic [NumStages-1:0] adv_f;
        logic                 all_full;
        adv_f = '0;
        for (int i = 0; i < int'(NumStages); i++) begin
            all_full = 1'b1;
            for (int j = i; j < int'(NumStages); j++) begin
                all_full &= v[j];
            end
            adv_f[i] = out_ready | ~all_full;
        end
        return adv_f;
    endfunction

    assign adv = stage_advance(valid_q, offload_resp_ready_i);

    always_comb begin
        up_valid    = '0;
        up_data     = '0;
        up_valid[0] = offload_req_valid_i;
        up_data[0]  = req_result;
        for (int i = 1; i < int'(NumStages); i++) begin
            up_valid[i] = valid_q[i-1];
            up_data[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= '0;
            data_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NumStages); i++) begin
                if (adv[i]) begin
                    valid_q[i] <= up_valid[i];
                    data_q[i]  <= up_data[i];
                end
            end
            if (offload_req_valid_i && adv[0] && !req_legal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign offload_req_ready_o   = adv[0];
    assign offload_resp_valid_o  = valid_q[LastStage];
    assign offload_resp_result_o = data_q[LastStage];
    assign illegal_op_o          = illegal_q;
    assign busy_o                = |valid_q;

endmodule

// File: tb/tb_floo_rd_offload_alu.sv
// Randomised and directed bench for floo_rd_offload_alu with a lane-level
// reference model and an in-order scoreboard.
module tb_floo_rd_offload_alu;
    import floo_rd_offload_alu_pkg::*;

    localparam int unsigned DW = 64;
    localparam int unsigned EW = 32;
    localparam int unsigned NS = 2;
    localparam int unsigned NL = DW / EW;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b1;
    rd_alu_op_e    req_op = RdAdd;
    logic [DW-1:0] op1 = '0;
    logic [DW-1:0] op2 = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] resp_result;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic          illegal_op;
    logic          busy;

    always #5 clk = ~clk;

    floo_rd_offload_alu #(
        .DataWidth(DW),
        .ElemWidth(EW),
        .NumStages(NS)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_ni),
        .offload_req_op_i      (req_op),
        .offload_req_operand1_i(op1),
        .offload_req_operand2_i(op2),
        .offload_req_valid_i   (req_valid),
        .offload_req_ready_o   (req_ready),
        .offload_resp_result_o (resp_result),
        .offload_resp_valid_o  (resp_valid),
        .offload_resp_ready_i  (resp_ready),
        .illegal_op_o          (illegal_op),
        .busy_o                (busy)
    );

    typedef struct {
        logic [DW-1:0] res;
        int            cyc;
    } sb_entry_t;

    sb_entry_t     sb[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            resp_cnt = 0;
    bit            lat_check = 1'b0;
    bit            cur_use = 1'b0;
    logic [DW-1:0] cur_exp = '0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_res = '0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Per-lane reference: signed compares via sign-extended 64-bit integers.
    function automatic logic [DW-1:0] model(input rd_alu_op_e op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic [EW-1:0] x, y;
        longint        sx, sy, ux, uy;
        r = '0;
        if (!(op inside {RdAdd, RdMinS, RdMaxS, RdMinU, RdMaxU, RdAnd, RdOr, RdXor})) return a;
        for (int k = 0; k < int'(NL); k++) begin
            x  = a[k*EW +: EW];
            y  = b[k*EW +: EW];
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            ux = longint'(x);
            uy = longint'(y);
            case (op)
                RdAdd:   r[k*EW +: EW] = EW'(ux + uy);
                RdMinS:  r[k*EW +: EW] = (sx <= sy) ? x : y;
                RdMaxS:  r[k*EW +: EW] = (sx >= sy) ? x : y;
                RdMinU:  r[k*EW +: EW] = (ux <= uy) ? x : y;
                RdMaxU:  r[k*EW +: EW] = (ux >= uy) ? x : y;
                RdAnd:   r[k*EW +: EW] = x & y;
                RdOr:    r[k*EW +: EW] = x | y;
                default: r[k*EW +: EW] = x ^ y;
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes observed mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        if (!rst_ni) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", resp_valid, 1);
                check("stall_hold_data", resp_result, prev_res);
            end
            if (resp_valid && resp_ready) begin
                resp_cnt++;
                if (sb.size() == 0) begin
                    check("resp_unexpected", resp_valid, 0);
                end else begin
                    sb_entry_t e;
                    e = sb.pop_front();
                    check("resp_data", resp_result, e.res);
                    if (lat_check) check("resp_latency", cyc - e.cyc, NS);
                end
            end
            if (req_valid && req_ready) begin
                sb_entry_t n;
                n.res = cur_use ? cur_exp : model(req_op, op1, op2);
                n.cyc = cyc;
                sb.push_back(n);
            end
            prev_stall = resp_valid && !resp_ready;
            prev_res   = resp_result;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input rd_alu_op_e op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input bit use_exp, input logic [DW-1:0] exp);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        req_op = op; op1 = a; op2 = b; req_valid = 1'b1;
        cur_use = use_exp; cur_exp = exp;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        cur_use = 1'b0;
        check("send_accept", ok, 1);
    endtask

    task automatic send_rand();
        send(rd_alu_op_e'(5'($urandom_range(7))), {$urandom, $urandom}, {$urandom, $urandom},
             1'b0, '0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_busy", busy, 0);
        check("drain_sb", sb.size(), 0);
    endtask

    task automatic rand_phase(input int n, input bit rand_rdy, input bit allow_illegal);
        bit took;
        for (int k = 0; k < n; k++) begin
            if (!req_valid && $urandom_range(3) != 0) begin
                req_valid = 1'b1;
                req_op = allow_illegal ? rd_alu_op_e'(5'($urandom_range(31)))
                                       : rd_alu_op_e'(5'($urandom_range(7)));
                op1 = {$urandom, $urandom};
                case ($urandom_range(3))
                    0:       op2 = op1;
                    1:       op2 = ~op1;
                    2:       op2 = {32'h8000_0000, 32'h7FFF_FFFF};
                    default: op2 = {$urandom, $urandom};
                endcase
            end
            resp_ready = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
            @(negedge clk);
            took = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (took) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, c0;
        #1 rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_illegal", illegal_op, 0);
        check("rst_result", resp_result, 0);
        check("rst_req_ready", req_ready, 1);
        rst_ni = 1'b1;
        idle(2);

        // Directed arithmetic with latency checking.
        lat_check = 1'b1;
        send(RdAdd, 64'h00000001_FFFFFFFF, 64'h00000001_00000001, 1'b1, 64'h00000002_00000000);
        drain();
        send(RdMinS, 64'hFFFFFFFF_00000005, 64'h00000001_00000003, 1'b1, 64'hFFFFFFFF_00000003);
        send(RdMaxU, 64'hFFFFFFFF_00000005, 64'h00000001_00000003, 1'b1, 64'hFFFFFFFF_00000005);
        send(RdXor, 64'hFFFFFFFF_00000005, 64'h00000001_00000003, 1'b1, 64'hFFFFFFFE_00000006);
        drain();

        rand_phase(300, 1'b0, 1'b0);
        drain();

        // Backpressure: 4 back-to-back requests, output stalled for 5 cycles.
        lat_check = 1'b0;
        resp_ready = 1'b0;
        c0 = resp_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++) send_rand();
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("bp_req_ready", req_ready, 0);
                check("bp_busy", busy, 1);
                repeat (3) @(posedge clk);
                #1 resp_ready = 1'b1;
            end
        join
        drain();
        check("bp_resp_count", resp_cnt - c0, 4);

        // Full-pipe pass-through, then sustained 1 op/cycle.
        resp_ready = 1'b0;
        send_rand();
        send_rand();
        resp_ready = 1'b1;
        req_op = RdOr; op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom};
        req_valid = 1'b1;
        @(negedge clk);
        check("pt_req_ready", req_ready, 1);
        check("pt_resp_valid", resp_valid, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 15; i++) send_rand();
        check("pt_throughput", cyc - t0, 15);
        drain();

        // Illegal op: passthrough of operand1 and a sticky flag.
        lat_check = 1'b1;
        check("illegal_before", illegal_op, 0);
        send(rd_alu_op_e'(5'h1F), 64'hDEADBEEF_CAFEF00D, 64'h12345678_9ABCDEF0, 1'b1,
             64'hDEADBEEF_CAFEF00D);
        check("illegal_set", illegal_op, 1);
        send_rand();
        send_rand();
        drain();
        check("illegal_sticky_legal", illegal_op, 1);

        lat_check = 1'b0;
        rand_phase(400, 1'b1, 1'b1);
        drain();
        check("illegal_sticky_rand", illegal_op, 1);

        // Reset with two entries in flight.
        resp_ready = 1'b0;
        send_rand();
        send_rand();
        check("pre_rst_busy", busy, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_illegal", illegal_op, 0);
        sb.delete();
        c0 = resp_cnt;
        @(posedge clk);
        #1 rst_ni = 1'b1;
        resp_ready = 1'b1;
        idle(6);
        check("post_rst_no_resp", resp_cnt - c0, 0);
        check("post_rst_busy", busy, 0);

        lat_check = 1'b1;
        send(RdMaxS, 64'h80000000_00000001, 64'h7FFFFFFF_FFFFFFFF, 1'b1, 64'h7FFFFFFF_00000001);
        send(RdMinU, 64'h80000000_00000001, 64'h7FFFFFFF_FFFFFFFF, 1'b1, 64'h7FFFFFFF_00000001);
        send(RdAnd, 64'hF0F0F0F0_0F0F0F0F, 64'hFF00FF00_00FF00FF, 1'b1, 64'hF000F000_000F000F);
        drain();
        check("final_illegal", illegal_op, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
